dff_stim_seq: RTL
=================

// Module: dff_stim_seq
// PURPOSE
//  Upstream stimulus stage for the D flip-flop under test (dffalter).
//  Serialises a packed pattern onto the flop's data input (di), MSB first,
//  holding each bit for a programmable number of clocks.
//  Emits one clear pulse before the pattern and an optional preset pulse at a
//  chosen bit slot. Uses a start/busy/done handshake, so benches can run
//  sequences back to back instead of relying on free-running toggles.
// PARAMETERS
//  WIDTH   4  pattern length in bits (>=2)
//  DIV_W   8  width of the bit-period field
//  IDX_W   2  width of the preset slot index; must satisfy 2**IDX_W >= WIDTH
// PORTS
//  clk         in   1        system clock, rising-edge
//  clr_n       in   1        asynchronous active-low reset
//  start       in   1        request a new sequence
//  pattern     in   WIDTH    bits to serialise; MSB goes out first
//  bit_period  in   DIV_W    clocks per bit; 0 is treated as 1
//  pr_en       in   1        enable the preset pulse for this sequence
//  pr_idx      in   IDX_W    bit slot in which pr is asserted
//  di          out  1        serial data to the flop
//  clr_dff     out  1        clear to the flop, active-high, one clock wide
//  pr          out  1        preset to the flop, active-high
//  busy        out  1        sequence in progress
//  done        out  1        one-clock completion pulse
//  bit_idx     out  IDX_W    index of the slot on di (0 = MSB slot)
// BEHAVIOUR
//  - Reset: clr_n low forces state IDLE immediately.
//    All outputs go to 0: di, clr_dff, pr, busy, done, bit_idx.
//  - All outputs are registered; no combinational path from inputs to outputs.
//  - FSM states: IDLE, CLEAR, SHIFT, DONE.
//  - IDLE/DONE: if start=1 at an edge, the block samples pattern, bit_period,
//    pr_en and pr_idx into shadow registers and moves to CLEAR.
//    Input changes after that edge have no effect on the running sequence.
//  - start is ignored in CLEAR and SHIFT; there is no queueing.
//  - CLEAR lasts exactly 1 clock: clr_dff=1, busy=1, di=0. Next state is SHIFT.
//  - SHIFT, with P = max(bit_period, 1):
//    - di = shadow_pattern[WIDTH-1-bit_idx]; each slot lasts exactly P clocks.
//    - A DIV_W-bit down-counter runs from P-1 to 0. At 0 it reloads,
//      and bit_idx increments.
//    - After slot WIDTH-1 finishes, the next state is DONE.
//    - pr=1 for the whole of slot pr_idx when pr_en was sampled high; else pr=0.
//    - If pr_idx >= WIDTH, pr never asserts.
//  - DONE lasts 1 clock: done=1, busy=0, di=0, pr=0, bit_idx=0.
//    Next state is IDLE, or CLEAR if start=1 (back-to-back sequence).
//  - Timing: start sampled at edge k gives:
//    - clr_dff high in cycle k+1;
//    - first bit from edge k+1 for P clocks;
//    - done high in the cycle after edge k+1+WIDTH*P.
//    - busy stays high for 1+WIDTH*P cycles.
//  - clr_dff and pr are never high together. clr_dff only pulses in CLEAR.
//  - Reset asserted mid-sequence aborts it: no done pulse, and outputs clear
//    asynchronously. After reset release, the block waits in IDLE for start.
// TESTING
//  - Reset: hold clr_n=0 for 3 clocks -> all outputs 0; start during reset is
//    ignored.
//  - Basic: pattern=4'b1010, bit_period=2, pr_en=0.
//    -> clr_dff 1 clock; di = 1,1,0,0,1,1,0,0; done at cycle 10; busy 9 clocks.
//  - Period zero: pattern=4'b0110, bit_period=0.
//    -> behaves as P=1; di = 0,1,1,0; done at cycle 6.
//  - Preset: pattern=4'b1111, bit_period=3, pr_en=1, pr_idx=2.
//    -> pr high for cycles 8-10 only; never overlaps clr_dff.
//  - Handshake: pulse start mid-SHIFT -> no effect.
//    Start high in the DONE cycle -> clr_dff in the next cycle; new sequence
//    runs with the new pattern.
//  - Abort: drop clr_n during slot 2 -> outputs 0 immediately; no done pulse;
//    next start runs a full, correct sequence.

Source files
------------

// File: rtl/dff_stim_seq.sv
// Stimulus sequencer for the dffalter flop under test.
// Serialises a packed pattern onto di (MSB first). Each bit is held for a
// programmable number of clocks. A one-clock clear pulse precedes the
// pattern, and an optional preset pulse covers one chosen bit slot.
// A start/busy/done handshake lets sequences run back to back.
module dff_stim_seq #(
   parameter int WIDTH = 4,
   parameter int DIV_W = 8,
   parameter int IDX_W = 2
) (
   input  logic             i_clk,
   input  logic             i_clr_n,
   input  logic             i_start,
   input  logic [WIDTH-1:0] i_pattern,
   input  logic [DIV_W-1:0] i_bit_period,
   input  logic             i_pr_en,
   input  logic [IDX_W-1:0] i_pr_idx,
   output logic             o_di,
   output logic             o_clr_dff,
   output logic             o_pr,
   output logic             o_busy,
   output logic             o_done,
   output logic [IDX_W-1:0] o_bit_idx
);

   localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH - 1);
   localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

   typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_SHIFT, S_DONE} state_t;

   state_t           r_state;
   logic [DIV_W-1:0] r_cnt;
   logic             r_di;
   logic             r_clr_dff;
   logic             r_pr;
   logic             r_busy;
   logic             r_done;
   logic [IDX_W-1:0] r_bit_idx;

   // Shadow copies of the request; the pattern shifts left so its MSB is
   // always the next bit to present.
   logic [WIDTH-1:0] r_shift;
   logic [DIV_W-1:0] r_per;
   logic             r_pr_en;
   logic [IDX_W-1:0] r_pr_idx;

   logic             w_take;
   logic [DIV_W-1:0] w_per;
   logic [IDX_W-1:0] w_idx_nxt;
   logic             w_last;
   logic             w_slot_end;

   assign w_take     = i_start && ((r_state == S_IDLE) || (r_state == S_DONE));
   assign w_per      = (i_bit_period == '0) ? DIV_ONE : i_bit_period;
   assign w_idx_nxt  = r_bit_idx + IDX_ONE;
   assign w_last     = (r_bit_idx == IDX_LAST);
   assign w_slot_end = (r_state == S_SHIFT) && (r_cnt == '0);

   // Capture the request on acceptance; advance the pattern at each slot boundary.
   always_ff @(posedge i_clk) begin
      if (w_take) begin
         r_shift  <= i_pattern;
         r_per    <= w_per;
         r_pr_en  <= i_pr_en;
         r_pr_idx <= i_pr_idx;
      end else if (w_slot_end && !w_last) begin
         r_shift  <= r_shift << 1;
      end
   end

   // Sequencer FSM with every output registered.
   always_ff @(posedge i_clk or negedge i_clr_n) begin
      if (!i_clr_n) begin
         r_state   <= S_IDLE;
         r_cnt     <= '0;
         r_di      <= 1'b0;
         r_clr_dff <= 1'b0;
         r_pr      <= 1'b0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_bit_idx <= '0;
      end else begin
         case (r_state)
            S_IDLE, S_DONE: begin
               r_di      <= 1'b0;
               r_pr      <= 1'b0;
               r_done    <= 1'b0;
               r_bit_idx <= '0;
               if (i_start) begin
                  r_state   <= S_CLEAR;
                  r_clr_dff <= 1'b1;
                  r_busy    <= 1'b1;
               end else begin
                  r_state   <= S_IDLE;
                  r_clr_dff <= 1'b0;
                  r_busy    <= 1'b0;
               end
            end
            S_CLEAR: begin
               r_state   <= S_SHIFT;
               r_clr_dff <= 1'b0;
               r_busy    <= 1'b1;
               r_di      <= r_shift[WIDTH-1];
               r_pr      <= r_pr_en && (r_pr_idx == '0);
               r_bit_idx <= '0;
               r_cnt     <= r_per - DIV_ONE;
            end
            S_SHIFT: begin
               if (r_cnt != '0) begin
                  r_cnt <= r_cnt - DIV_ONE;
               end else if (w_last) begin
                  r_state   <= S_DONE;
                  r_done    <= 1'b1;
                  r_busy    <= 1'b0;
                  r_di      <= 1'b0;
                  r_pr      <= 1'b0;
                  r_bit_idx <= '0;
               end else begin
                  r_cnt     <= r_per - DIV_ONE;
                  r_bit_idx <= w_idx_nxt;
                  r_di      <= r_shift[WIDTH-2];
                  r_pr      <= r_pr_en && (r_pr_idx == w_idx_nxt);
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign o_di      = r_di;
   assign o_clr_dff = r_clr_dff;
   assign o_pr      = r_pr;
   assign o_busy    = r_busy;
   assign o_done    = r_done;
   assign o_bit_idx = r_bit_idx;

endmodule
